// File: rtl/spi_ram_ctrl.sv
// Bridges the SPI slave word stream and a local requester onto one synchronous RAM port.
// A one-deep SPI slot and a round-robin arbiter share the RAM; read bytes return to the requester.
module spi_ram_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic              loc_gnt,
  output logic [7:0]        loc_rdata,
  output logic              loc_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, SPI_ACC, LOC_ACC, RD_RSP} state_t;

  state_t              state_reg, state_next;
  logic                spi_pend_reg, spi_pend_next;
  logic                spi_we_reg, spi_we_next;
  logic [ADDR_W-1:0]   spi_addr_reg, spi_addr_next;
  logic [7:0]          spi_data_reg, spi_data_next;
  logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic                rd_ok_reg, rd_ok_next;
  logic                last_loc_reg, last_loc_next;
  logic                rsp_spi_reg, rsp_spi_next;
  logic                err_reg, err_next;
  logic                mem_en_reg, mem_en_next;
  logic                mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [7:0]          mem_wdata_reg, mem_wdata_next;
  logic [7:0]          tx_data_reg, tx_data_next;
  logic                tx_valid_reg, tx_valid_next;
  logic [7:0]          loc_rdata_reg, loc_rdata_next;
  logic                loc_rvalid_reg, loc_rvalid_next;

  logic [1:0]          opcode;
  logic [7:0]          payload;
  logic                slot_free;
  logic                grant_spi;
  logic                grant_loc;

  assign opcode  = rx_data[9:8];
  assign payload = rx_data[7:0];

  // The slot frees in the very cycle its access is on the RAM port.
  assign slot_free = !spi_pend_reg || (state_reg == SPI_ACC);

  assign grant_spi = (state_reg == IDLE) && spi_pend_reg && (!loc_req || last_loc_reg);
  assign grant_loc = (state_reg == IDLE) && loc_req && (!spi_pend_reg || !last_loc_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      spi_pend_reg   <= 1'b0;
      spi_we_reg     <= 1'b0;
      spi_addr_reg   <= '0;
      spi_data_reg   <= 8'h00;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      rd_ok_reg      <= 1'b0;
      last_loc_reg   <= 1'b1;
      rsp_spi_reg    <= 1'b0;
      err_reg        <= 1'b0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= 8'h00;
      tx_data_reg    <= 8'h00;
      tx_valid_reg   <= 1'b0;
      loc_rdata_reg  <= 8'h00;
      loc_rvalid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      spi_pend_reg   <= spi_pend_next;
      spi_we_reg     <= spi_we_next;
      spi_addr_reg   <= spi_addr_next;
      spi_data_reg   <= spi_data_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      rd_ok_reg      <= rd_ok_next;
      last_loc_reg   <= last_loc_next;
      rsp_spi_reg    <= rsp_spi_next;
      err_reg        <= err_next;
      mem_en_reg     <= mem_en_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      tx_data_reg    <= tx_data_next;
      tx_valid_reg   <= tx_valid_next;
      loc_rdata_reg  <= loc_rdata_next;
      loc_rvalid_reg <= loc_rvalid_next;
    end
  end

  // Command decode into the SPI slot and the address pointers.
  always_comb begin
    spi_pend_next = spi_pend_reg;
    spi_we_next   = spi_we_reg;
    spi_addr_next = spi_addr_reg;
    spi_data_next = spi_data_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    rd_ok_next    = rd_ok_reg;
    err_next      = err_reg;

    if (state_reg == SPI_ACC) begin
      spi_pend_next = 1'b0;
    end

    if (rx_valid) begin
      case (opcode)
        2'b00: wr_ptr_next = ADDR_W'(payload);
        2'b01: begin
          if (slot_free) begin
            spi_pend_next = 1'b1;
            spi_we_next   = 1'b1;
            spi_addr_next = wr_ptr_reg;
            spi_data_next = payload;
            wr_ptr_next   = wr_ptr_reg + 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
        2'b10: begin
          rd_ptr_next = ADDR_W'(payload);
          rd_ok_next  = 1'b1;
        end
        default: begin
          if (rd_ok_reg && slot_free) begin
            spi_pend_next = 1'b1;
            spi_we_next   = 1'b0;
            spi_addr_next = rd_ptr_reg;
            rd_ptr_next   = rd_ptr_reg + 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      endcase
    end
  end

  // Arbiter and RAM sequencing.
  always_comb begin
    state_next      = state_reg;
    last_loc_next   = last_loc_reg;
    rsp_spi_next    = rsp_spi_reg;
    mem_en_next     = 1'b0;
    mem_we_next     = 1'b0;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    tx_data_next    = tx_data_reg;
    tx_valid_next   = 1'b0;
    loc_rdata_next  = loc_rdata_reg;
    loc_rvalid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_spi) begin
          state_next     = SPI_ACC;
          mem_en_next    = 1'b1;
          mem_we_next    = spi_we_reg;
          mem_addr_next  = spi_addr_reg;
          mem_wdata_next = spi_data_reg;
          last_loc_next  = 1'b0;
          rsp_spi_next   = 1'b1;
        end else if (grant_loc) begin
          state_next     = LOC_ACC;
          mem_en_next    = 1'b1;
          mem_we_next    = loc_we;
          mem_addr_next  = loc_addr;
          mem_wdata_next = loc_wdata;
          last_loc_next  = 1'b1;
          rsp_spi_next   = 1'b0;
        end
      end
      SPI_ACC, LOC_ACC: begin
        state_next = mem_we_reg ? IDLE : RD_RSP;
      end
      RD_RSP: begin
        state_next = IDLE;
        if (rsp_spi_reg) begin
          tx_data_next  = mem_rdata;
          tx_valid_next = 1'b1;
        end else begin
          loc_rdata_next  = mem_rdata;
          loc_rvalid_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_data    = tx_data_reg;
  assign tx_valid   = tx_valid_reg;
  assign loc_gnt    = (state_reg == LOC_ACC);
  assign loc_rdata  = loc_rdata_reg;
  assign loc_rvalid = loc_rvalid_reg;
  assign mem_en     = mem_en_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: a transaction-level model predicts RAM accesses,
// returned bytes and the error flag; a per-cycle monitor checks the DUT against it.
module tb_spi_ram_ctrl;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rx_data = 10'h000;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       loc_req = 1'b0;
  logic       loc_we = 1'b0;
  logic [7:0] loc_addr = 8'h00;
  logic [7:0] loc_wdata = 8'h00;
  logic       loc_gnt;
  logic [7:0] loc_rdata;
  logic       loc_rvalid;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       err;

  spi_ram_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_gnt(loc_gnt), .loc_rdata(loc_rdata), .loc_rvalid(loc_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM macro: registered read, data valid the cycle after the enable.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Transaction-level model
  logic [7:0] m_wp, m_rp;
  bit         m_rdok, m_err;
  bit         m_err_q;
  logic [7:0] m_mem [256];
  acc_t       spi_q[$];
  acc_t       loc_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] lrd_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) m_err_q <= 1'b0;
    else     m_err_q <= m_err;
  end

  task automatic model_reset();
    m_wp = 8'h00; m_rp = 8'h00; m_rdok = 1'b0; m_err = 1'b0;
    spi_q.delete(); loc_q.delete(); tx_q.delete(); lrd_q.delete();
  endtask

  // busy: the directed vector states that the previous SPI access has not yet reached the RAM.
  task automatic model_spi(input logic [9:0] w, input bit busy);
    logic [7:0] p;
    acc_t a;
    p = w[7:0];
    case (w[9:8])
      2'b00: m_wp = p;
      2'b01: begin
        if (busy) m_err = 1'b1;
        else begin
          a.we = 1'b1; a.addr = m_wp; a.data = p;
          spi_q.push_back(a);
          m_mem[m_wp] = p;
          m_wp = m_wp + 8'h01;
        end
      end
      2'b10: begin m_rp = p; m_rdok = 1'b1; end
      default: begin
        if (!m_rdok || busy) m_err = 1'b1;
        else begin
          a.we = 1'b0; a.addr = m_rp; a.data = 8'h00;
          spi_q.push_back(a);
          tx_q.push_back(m_mem[m_rp]);
          m_rp = m_rp + 8'h01;
        end
      end
    endcase
  endtask

  // Monitor
  acc_t       ce;
  acc_t       spi_log[$];
  int         spi_cyc[$];
  logic [7:0] tx_log[$];
  bit         gnt_log[$];
  int         tx_cyc_last = 0;
  int         n_tx = 0;
  int         n_lrv = 0;
  int         n_gnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("err", err, m_err_q);
      if (mem_we && !mem_en) fail_now("mem_we_without_mem_en");
      if (mem_en) begin
        ce.we = mem_we; ce.addr = mem_addr; ce.data = mem_wdata;
        if (loc_gnt) begin
          gnt_log.push_back(1'b1);
          n_gnt++;
          if (loc_q.size() == 0) fail_now("unexpected_local_access");
          else begin
            acc_t e;
            e = loc_q.pop_front();
            chk("loc_we", mem_we, e.we);
            chk("loc_addr", mem_addr, e.addr);
            if (e.we) chk("loc_wdata", mem_wdata, e.data);
          end
        end else begin
          gnt_log.push_back(1'b0);
          spi_log.push_back(ce);
          spi_cyc.push_back(cyc);
          if (spi_q.size() == 0) fail_now("unexpected_spi_access");
          else begin
            acc_t e;
            e = spi_q.pop_front();
            chk("spi_we", mem_we, e.we);
            chk("spi_addr", mem_addr, e.addr);
            if (e.we) chk("spi_wdata", mem_wdata, e.data);
          end
        end
      end else if (loc_gnt) begin
        fail_now("loc_gnt_without_mem_en");
      end
      if (tx_valid) begin
        n_tx++;
        tx_cyc_last = cyc;
        tx_log.push_back(tx_data);
        if (tx_q.size() == 0) fail_now("unexpected_tx_valid");
        else chk("tx_data", tx_data, tx_q.pop_front());
      end
      if (loc_rvalid) begin
        n_lrv++;
        if (lrd_q.size() == 0) fail_now("unexpected_loc_rvalid");
        else chk("loc_rdata", loc_rdata, lrd_q.pop_front());
      end
    end
  end

  // Stimulus helpers: every task starts and ends 1 time unit after a rising edge.
  int last_rx_cyc = 0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [9:0] w, input bit busy = 1'b0);
    rx_data = w; rx_valid = 1'b1;
    model_spi(w, busy);
    last_rx_cyc = cyc;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic loc_start(input logic we, input logic [7:0] addr, input logic [7:0] data);
    acc_t a;
    loc_we = we; loc_addr = addr; loc_wdata = data; loc_req = 1'b1;
    a.we = we; a.addr = addr; a.data = data;
    loc_q.push_back(a);
    if (we) m_mem[addr] = data;
    else    lrd_q.push_back(m_mem[addr]);
  endtask

  task automatic wait_gnt();
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (loc_gnt) return;
    end
    fail_now("loc_gnt_timeout");
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_loc_gnt"}, loc_gnt, 0);
    chk({tag, "_loc_rdata"}, loc_rdata, 0);
    chk({tag, "_loc_rvalid"}, loc_rvalid, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic clear_logs();
    spi_log.delete(); spi_cyc.delete(); tx_log.delete(); gnt_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c_w, c_r, t0, l0, g0;
    model_reset();
    #1;
    check_zero("por");
    tick(2);
    rst = 1'b0;
    tick(2);

    // Write then read back
    clear_logs();
    send(10'h03C); tick(9);
    send(10'h1A5); c_w = last_rx_cyc; tick(9);
    send(10'h23C); tick(9);
    send(10'h300); c_r = last_rx_cyc; tick(9);
    chk("t1_access_count", spi_log.size(), 2);
    chk("t1_wr_addr", spi_log[0].addr, 8'h3C);
    chk("t1_wr_data", spi_log[0].data, 8'hA5);
    chk("t1_wr_latency", spi_cyc[0] - c_w, 2);
    chk("t1_rd_we", spi_log[1].we, 0);
    chk("t1_rd_addr", spi_log[1].addr, 8'h3C);
    chk("t1_tx_byte", tx_log[0], 8'hA5);
    chk("t1_tx_latency", tx_cyc_last - c_r, 4);

    // Pointer increment and wrap
    clear_logs();
    send(10'h0FF); tick(9);
    send(10'h111); tick(9);
    send(10'h122); tick(9);
    send(10'h2FF); tick(9);
    send(10'h300); tick(9);
    send(10'h3AB); tick(9);
    chk("t2_w0_addr", spi_log[0].addr, 8'hFF);
    chk("t2_w0_data", spi_log[0].data, 8'h11);
    chk("t2_w1_addr", spi_log[1].addr, 8'h00);
    chk("t2_w1_data", spi_log[1].data, 8'h22);
    chk("t2_r0_addr", spi_log[2].addr, 8'hFF);
    chk("t2_r1_addr", spi_log[3].addr, 8'h00);
    chk("t2_tx0", tx_log[0], 8'h11);
    chk("t2_tx1", tx_log[1], 8'h22);

    // Read without address
    do_reset();
    clear_logs();
    t0 = n_tx;
    send(10'h300); tick(9);
    chk("t3_err", err, 1);
    chk("t3_no_access", spi_log.size(), 0);
    chk("t3_no_tx", n_tx - t0, 0);
    tick(20);
    chk("t3_err_sticky", err, 1);
    do_reset();
    chk("t3_err_cleared", err, 0);

    // Round-robin tie, twice
    clear_logs();
    g0 = n_gnt;
    send(10'h010); tick(9);
    for (int k = 0; k < 2; k++) begin
      rx_data = (k == 0) ? 10'h155 : 10'h177;
      rx_valid = 1'b1;
      model_spi(rx_data, 1'b0);
      tick(1);
      rx_valid = 1'b0;
      loc_start(1'b1, 8'h80 + 8'(k), 8'h66 + 8'(k));
      wait_gnt();
      loc_req = 1'b0;
      tick(9);
    end
    chk("t4_gnt_count", gnt_log.size(), 4);
    chk("t4_first_spi", gnt_log[0], 0);
    chk("t4_then_loc", gnt_log[1], 1);
    chk("t4_second_spi", gnt_log[2], 0);
    chk("t4_second_loc", gnt_log[3], 1);
    chk("t4_loc_pulses", n_gnt - g0, 2);
    chk("t4_spi_addr", spi_log[0].addr, 8'h10);
    chk("t4_spi_data", spi_log[0].data, 8'h55);

    // Overflow with the local port hogging
    send(10'h020); tick(3);
    clear_logs();
    l0 = n_lrv;
    fork
      begin
        loc_start(1'b0, 8'h80, 8'h00);
        for (int i = 0; i < 6; i++) begin
          wait_gnt();
          if (i < 5) loc_start(1'b0, 8'h80, 8'h00);
        end
        loc_req = 1'b0;
      end
      begin
        tick(2);
        send(10'h177, 1'b0);
        send(10'h188, 1'b1);
      end
    join
    tick(10);
    chk("t5_err", err, 1);
    chk("t5_one_write", spi_log.size(), 1);
    chk("t5_write_addr", spi_log[0].addr, 8'h20);
    chk("t5_write_data", spi_log[0].data, 8'h77);
    chk("t5_loc_reads", n_lrv - l0, 6);
    send(10'h199); tick(9);
    chk("t5_ptr_unchanged", spi_log[1].addr, 8'h21);

    // Reset in the middle of a read
    do_reset();
    send(10'h280); tick(9);
    clear_logs();
    send(10'h300);
    tick(2);
    chk("t6_read_issued", spi_log.size(), 1);
    t0 = n_tx; l0 = n_lrv;
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("t6_mid");
    tick(1);
    rst = 1'b0;
    tick(10);
    chk("t6_no_tx", n_tx - t0, 0);
    chk("t6_no_lrv", n_lrv - l0, 0);
    check_zero("t6_after");

    chk("end_spi_q", spi_q.size(), 0);
    chk("end_loc_q", loc_q.size(), 0);
    chk("end_tx_q", tx_q.size(), 0);
    chk("end_lrd_q", lrd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
